// File: rtl/arb_mux_n.sv
// arb_mux_n: NUM_IN-to-1 arbitrated mux with a single registered output stage.
// Define ARB_MUX_N_LAST_LOCK_EN to add in_last/out_last and hold the grant until a packet's last beat.
module arb_mux_n #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 4,
    parameter int RR_EN  = 1,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
`ifdef ARB_MUX_N_LAST_LOCK_EN
    input  logic [NUM_IN-1:0]       in_last,
    output logic                    out_last,
`endif
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_sel
);
    logic [SEL_W-1:0] ptr, base, lo_gnt, hi_gnt, rr_gnt, gnt;
    logic             hit_lo, hit_hi, gnt_ok, load, accept, ptr_upd;

    assign base = (RR_EN != 0) ? ptr : '0;

    // lo_* is the lowest valid index overall, hi_* the lowest at or above base; hi wins, lo is the wrap.
    always_comb begin
        lo_gnt = '0;
        hi_gnt = '0;
        hit_lo = 1'b0;
        hit_hi = 1'b0;
        for (int j = NUM_IN - 1; j >= 0; j--) begin
            if (in_valid[j]) begin
                lo_gnt = SEL_W'(j);
                hit_lo = 1'b1;
                if (j >= int'(base)) begin
                    hi_gnt = SEL_W'(j);
                    hit_hi = 1'b1;
                end
            end
        end
    end

    assign rr_gnt = hit_hi ? hi_gnt : lo_gnt;

`ifdef ARB_MUX_N_LAST_LOCK_EN
    localparam logic IDLE   = 1'b0;
    localparam logic LOCKED = 1'b1;
    logic             state;
    logic [SEL_W-1:0] lock_ch;
    assign gnt     = (state == LOCKED) ? lock_ch : rr_gnt;
    assign gnt_ok  = (state == LOCKED) ? in_valid[lock_ch] : hit_lo;
    // the pointer only advances once a packet completes
    assign ptr_upd = accept && in_last[gnt];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else if (accept) begin
            out_last <= in_last[gnt];
            if (state == IDLE && !in_last[gnt]) begin
                state   <= LOCKED;
                lock_ch <= gnt;
            end else if (state == LOCKED && in_last[gnt]) begin
                state <= IDLE;
            end
        end
    end
`else
    assign gnt     = rr_gnt;
    assign gnt_ok  = hit_lo;
    assign ptr_upd = accept;
`endif

    assign load     = !out_valid || out_ready;
    assign accept   = load && gnt_ok && !reset;
    assign in_ready = accept ? NUM_IN'(1) << gnt : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (load)
                out_valid <= accept;
            if (accept) begin
                out_data <= in_data[int'(gnt)*WIDTH +: WIDTH];
                out_sel  <= gnt;
            end
            if (ptr_upd && RR_EN != 0)
                ptr <= (gnt == SEL_W'(NUM_IN - 1)) ? '0 : gnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: scoreboard bench for round-robin, fixed-priority and 3-input arb_mux_n instances.
module tb_arb_mux_n;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] rr_d;
    logic [3:0]  rr_v, rr_rdy;
    logic [7:0]  rr_od;
    logic        rr_ov, rr_or;
    logic [1:0]  rr_sel;
`ifdef ARB_MUX_N_LAST_LOCK_EN
    logic [3:0]  rr_last, fp_last;
    logic [2:0]  r3_last;
    logic        rr_ol, fp_ol, r3_ol;
`endif
    logic [31:0] fp_d;
    logic [3:0]  fp_v, fp_rdy;
    logic [7:0]  fp_od;
    logic        fp_ov, fp_or;
    logic [1:0]  fp_sel;
    logic [23:0] r3_d;
    logic [2:0]  r3_v, r3_rdy;
    logic [7:0]  r3_od;
    logic        r3_ov, r3_or;
    logic [1:0]  r3_sel;

    arb_mux_n #(.WIDTH(8), .NUM_IN(4), .RR_EN(1)) u_rr (
        .clk(clk), .reset(reset), .in_data(rr_d), .in_valid(rr_v), .in_ready(rr_rdy),
`ifdef ARB_MUX_N_LAST_LOCK_EN
        .in_last(rr_last), .out_last(rr_ol),
`endif
        .out_data(rr_od), .out_valid(rr_ov), .out_ready(rr_or), .out_sel(rr_sel));

    arb_mux_n #(.WIDTH(8), .NUM_IN(4), .RR_EN(0)) u_fp (
        .clk(clk), .reset(reset), .in_data(fp_d), .in_valid(fp_v), .in_ready(fp_rdy),
`ifdef ARB_MUX_N_LAST_LOCK_EN
        .in_last(fp_last), .out_last(fp_ol),
`endif
        .out_data(fp_od), .out_valid(fp_ov), .out_ready(fp_or), .out_sel(fp_sel));

    arb_mux_n #(.WIDTH(8), .NUM_IN(3), .RR_EN(1)) u_r3 (
        .clk(clk), .reset(reset), .in_data(r3_d), .in_valid(r3_v), .in_ready(r3_rdy),
`ifdef ARB_MUX_N_LAST_LOCK_EN
        .in_last(r3_last), .out_last(r3_ol),
`endif
        .out_data(r3_od), .out_valid(r3_ov), .out_ready(r3_or), .out_sel(r3_sel));

    int checks = 0;
    int failures = 0;
    logic [9:0] q_rr[$], q_fp[$], q_r3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitors: every handshake on an output pops and compares {sel, data}
    always @(negedge clk) begin
        if (!reset && rr_ov && rr_or) begin
            if (q_rr.size() == 0) chk("rr_unexpected_beat", 32'({rr_sel, rr_od}), 32'h3ff);
            else chk("rr_beat", 32'({rr_sel, rr_od}), 32'(q_rr.pop_front()));
        end
        if (!reset && fp_ov && fp_or) begin
            if (q_fp.size() == 0) chk("fp_unexpected_beat", 32'({fp_sel, fp_od}), 32'h3ff);
            else chk("fp_beat", 32'({fp_sel, fp_od}), 32'(q_fp.pop_front()));
        end
        if (!reset && r3_ov && r3_or) begin
            if (q_r3.size() == 0) chk("r3_unexpected_beat", 32'({r3_sel, r3_od}), 32'h3ff);
            else chk("r3_beat", 32'({r3_sel, r3_od}), 32'(q_r3.pop_front()));
        end
    end

    initial begin
        reset = 1'b1;
        rr_d = {8'h40, 8'h30, 8'hAA, 8'h10};
        fp_d = {8'h33, 8'h22, 8'h11, 8'h00};
        r3_d = {8'hA2, 8'hA1, 8'hA0};
        rr_v = 4'hF; fp_v = 4'h0; r3_v = 3'h0;
        rr_or = 1'b1; fp_or = 1'b1; r3_or = 1'b1;
`ifdef ARB_MUX_N_LAST_LOCK_EN
        rr_last = 4'hF; fp_last = 4'hF; r3_last = 3'h7;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(rr_ov), 0);
        chk("rst_out_data", 32'(rr_od), 0);
        chk("rst_in_ready", 32'(rr_rdy), 0);
        chk("rst_out_sel", 32'(rr_sel), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // all valid, always ready: grants rotate 0,1,2,3,0 back to back
        q_rr.push_back({2'd0, 8'h10}); q_rr.push_back({2'd1, 8'hAA});
        q_rr.push_back({2'd2, 8'h30}); q_rr.push_back({2'd3, 8'h40});
        q_rr.push_back({2'd0, 8'h10});
        repeat (5) step();

        // load 0xAA from ch1, then stall three cycles with everything valid
        rr_v = 4'b0010;
        q_rr.push_back({2'd1, 8'hAA});
        step();
        rr_or = 1'b0;
        rr_v = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(rr_rdy), 0);
            chk("stall_out_data", 32'(rr_od), 32'hAA);
            chk("stall_out_valid", 32'(rr_ov), 1);
            step();
        end
        rr_or = 1'b1;
        q_rr.push_back({2'd2, 8'h30}); q_rr.push_back({2'd3, 8'h40});
        q_rr.push_back({2'd0, 8'h10});
        repeat (3) step();
        rr_v = 4'h0;
        step();

        // move ptr to 3, then reset during a stall
        rr_v = 4'b0100;
        rr_or = 1'b0;
        step();
        rr_v = 4'hF;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(rr_ov), 0);
        chk("async_rst_out_data", 32'(rr_od), 0);
        chk("async_rst_in_ready", 32'(rr_rdy), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        rr_or = 1'b1;
        q_rr.push_back({2'd0, 8'h10});
        step();
`ifdef ARB_MUX_N_LAST_LOCK_EN
        // ch1 three-beat packet holds the grant despite ch0/ch2 valid
        rr_v = 4'b0111;
        rr_last = 4'b1101;
        q_rr.push_back({2'd1, 8'hAA}); q_rr.push_back({2'd1, 8'hAA});
        q_rr.push_back({2'd1, 8'hAA}); q_rr.push_back({2'd2, 8'h30});
        repeat (2) step();
        rr_last = 4'hF;
        repeat (2) step();
`endif
        rr_v = 4'h0;

        // fixed priority: ch1 starves ch3
        fp_v = 4'b1010;
        q_fp.push_back({2'd1, 8'h11}); q_fp.push_back({2'd1, 8'h11});
        q_fp.push_back({2'd1, 8'h11});
        step();
        @(negedge clk);
        chk("fp_starve_ready", 32'(fp_rdy), 32'b0010);
        repeat (2) step();
        fp_v = 4'b1000;
        q_fp.push_back({2'd3, 8'h33});
        step();
        fp_v = 4'b1100;
        q_fp.push_back({2'd2, 8'h22});
        step();
        fp_v = 4'h0;

        // three inputs: pointer wraps 2 -> 0
        r3_v = 3'b100;
        q_r3.push_back({2'd2, 8'hA2});
        step();
        r3_v = 3'b111;
        q_r3.push_back({2'd0, 8'hA0}); q_r3.push_back({2'd1, 8'hA1});
        q_r3.push_back({2'd2, 8'hA2}); q_r3.push_back({2'd0, 8'hA0});
        repeat (4) step();
        r3_v = 3'b000;

        repeat (4) step();
        chk("rr_queue_empty", 32'(q_rr.size()), 0);
        chk("fp_queue_empty", 32'(q_fp.size()), 0);
        chk("r3_queue_empty", 32'(q_r3.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
